// File: rtl/tt_memop_issue_arb.sv
// ---------------------------------------------------------------------------
// tt_memop_issue_arb
//
// Purpose:
//   Chooses between the vector load uop stream and the vector store uop
//   stream for the single shared memop sequencing FSM. A grant covers one
//   whole instruction, which is every uop up to and including last_uop.
//   After the last uop is accepted the arbiter waits for the memop FSM's
//   completion pulse before it arbitrates again. A credit counter tracks
//   outstanding memory requests so that the load path cannot overrun the
//   load queue.
//
// Handshake:
//   Every rts/rtr pair is a valid/ready pair. A uop transfers on a cycle
//   where rts && rtr are both 1. rtr may be 1 while rts is 0, and that is
//   not a transfer. Once rts is raised, the source holds its payload
//   (last_uop) steady until the transfer happens.
//
// Ports:
//   i_clk, i_reset_n         clock; synchronous active-low reset
//   i_ld_rts/i_ld_last_uop   load uop valid / last uop of its instruction
//   o_ld_rtr                 load uop accepted (when i_ld_rts=1)
//   i_st_rts/i_st_last_uop   store uop valid / last uop of its instruction
//   o_st_rtr                 store uop accepted (when i_st_rts=1)
//   o_ex_rts                 uop valid toward the memop FSM / EX
//   o_ex_load/o_ex_store     the forwarded uop is a load / a store
//   o_ex_last_uop            forwarded last_uop
//   i_ex_rtr                 EX ready
//   i_completed_valid        memop FSM commit pulse
//   i_mem_req/o_mem_req_rdy  memory request attempt / credit available
//   i_mem_resp               memory response, returns one credit
//   o_outst_cnt              current outstanding request count
//   o_busy                   arbiter is not in IDLE (debug view of state)
//   o_err                    sticky protocol error
// ---------------------------------------------------------------------------
module tt_memop_issue_arb #(
  parameter int MAX_OUTST = 16,
  parameter int CNT_W     = $clog2(MAX_OUTST + 1)
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_ld_rts,
  input  logic             i_ld_last_uop,
  output logic             o_ld_rtr,
  input  logic             i_st_rts,
  input  logic             i_st_last_uop,
  output logic             o_st_rtr,
  output logic             o_ex_rts,
  output logic             o_ex_load,
  output logic             o_ex_store,
  output logic             o_ex_last_uop,
  input  logic             i_ex_rtr,
  input  logic             i_completed_valid,
  input  logic             i_mem_req,
  output logic             o_mem_req_rdy,
  input  logic             i_mem_resp,
  output logic [CNT_W-1:0] o_outst_cnt,
  output logic             o_busy,
  output logic             o_err
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_GNT_LD    = 2'd1,
    ST_GNT_ST    = 2'd2,
    ST_WAIT_CMPL = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTST);

  state_t           state_q, state_d;
  // 1 = the store stream received the most recent grant
  logic             last_grant_st_q, last_grant_st_d;
  logic [CNT_W-1:0] outst_cnt_q;
  logic             err_q;

  // Raw FSM outputs. These are masked with reset further down.
  logic ld_rtr, st_rtr, ex_rts, ex_load, ex_store, ex_last;
  logic cmpl_err;

  // -------------------------------------------------------------------------
  // FSM state register
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q         <= ST_IDLE;
      last_grant_st_q <= 1'b1;  // STORE, so a load wins the first contest
    end else begin
      state_q         <= state_d;
      last_grant_st_q <= last_grant_st_d;
    end
  end

  // -------------------------------------------------------------------------
  // FSM next-state and outputs
  // -------------------------------------------------------------------------
  always_comb begin
    state_d         = state_q;
    last_grant_st_d = last_grant_st_q;
    ld_rtr          = 1'b0;
    st_rtr          = 1'b0;
    ex_rts          = 1'b0;
    ex_load         = 1'b0;
    ex_store        = 1'b0;
    ex_last         = 1'b0;
    cmpl_err        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // The decision is registered, so the winner sees its first rtr one
        // cycle later. No uop moves while the arbiter is in IDLE.
        if (i_ld_rts && i_st_rts) begin
          if (last_grant_st_q) begin
            state_d         = ST_GNT_LD;
            last_grant_st_d = 1'b0;
          end else begin
            state_d         = ST_GNT_ST;
            last_grant_st_d = 1'b1;
          end
        end else if (i_ld_rts) begin
          state_d         = ST_GNT_LD;
          last_grant_st_d = 1'b0;
        end else if (i_st_rts) begin
          state_d         = ST_GNT_ST;
          last_grant_st_d = 1'b1;
        end
        cmpl_err = i_completed_valid;
      end

      ST_GNT_LD: begin
        ex_rts  = i_ld_rts;
        ex_last = i_ld_last_uop;
        ex_load = 1'b1;
        ld_rtr  = i_ex_rtr;
        // The grant holds until the last uop transfers, even if rts drops.
        if (i_ld_rts && i_ex_rtr && i_ld_last_uop) state_d = ST_WAIT_CMPL;
        cmpl_err = i_completed_valid;
      end

      ST_GNT_ST: begin
        ex_rts   = i_st_rts;
        ex_last  = i_st_last_uop;
        ex_store = 1'b1;
        st_rtr   = i_ex_rtr;
        if (i_st_rts && i_ex_rtr && i_st_last_uop) state_d = ST_WAIT_CMPL;
        cmpl_err = i_completed_valid;
      end

      ST_WAIT_CMPL: begin
        if (i_completed_valid) begin
          state_d = ST_IDLE;
          // An instruction should not commit while it still has requests
          // in flight.
          cmpl_err = (outst_cnt_q != '0);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Nothing may appear to transfer during a reset cycle, even if the state
  // register still holds a grant.
  assign o_ld_rtr      = ld_rtr   & i_reset_n;
  assign o_st_rtr      = st_rtr   & i_reset_n;
  assign o_ex_rts      = ex_rts   & i_reset_n;
  assign o_ex_load     = ex_load  & i_reset_n;
  assign o_ex_store    = ex_store & i_reset_n;
  assign o_ex_last_uop = ex_last  & i_reset_n;
  assign o_busy        = (state_q != ST_IDLE);

  // -------------------------------------------------------------------------
  // Outstanding-request credit counter. It runs independently of the FSM.
  // -------------------------------------------------------------------------
  logic cnt_inc, cnt_dec, underflow;

  assign o_mem_req_rdy = (outst_cnt_q < MAX_CNT);
  assign cnt_inc       = i_mem_req && o_mem_req_rdy;
  assign cnt_dec       = i_mem_resp;
  // When a request and a response land together the net change is zero, so
  // that case is not treated as an underflow.
  assign underflow     = cnt_dec && !cnt_inc && (outst_cnt_q == '0);

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      outst_cnt_q <= '0;
    end else begin
      case ({cnt_inc, cnt_dec})
        2'b10:   outst_cnt_q <= outst_cnt_q + 1'b1;
        2'b01:   if (outst_cnt_q != '0) outst_cnt_q <= outst_cnt_q - 1'b1;
        default: outst_cnt_q <= outst_cnt_q;
      endcase
    end
  end

  assign o_outst_cnt = outst_cnt_q;

  // -------------------------------------------------------------------------
  // Sticky error flag
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      err_q <= 1'b0;
    end else if (underflow || cmpl_err) begin
      err_q <= 1'b1;
    end
  end

  assign o_err = err_q;

endmodule

// File: tb/tb_tt_memop_issue_arb.sv
// ---------------------------------------------------------------------------
// tb_tt_memop_issue_arb
//
// Directed bench for tt_memop_issue_arb. Inputs change 1 ns after the
// rising edge. Point checks are made 1 ns after that. The EX-side monitor
// samples on the falling edge and pops one expected record for every
// accepted uop.
// ---------------------------------------------------------------------------
module tb_tt_memop_issue_arb;

  localparam int MAX_OUTST = 16;
  localparam int CNT_W     = $clog2(MAX_OUTST + 1);
  localparam int W         = 5;  // {ex_load, ex_store, ex_last, ld_rtr, st_rtr}

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             i_reset_n;
  logic             i_ld_rts, i_ld_last_uop, o_ld_rtr;
  logic             i_st_rts, i_st_last_uop, o_st_rtr;
  logic             o_ex_rts, o_ex_load, o_ex_store, o_ex_last_uop;
  logic             i_ex_rtr, i_completed_valid;
  logic             i_mem_req, o_mem_req_rdy, i_mem_resp;
  logic [CNT_W-1:0] o_outst_cnt;
  logic             o_busy, o_err;

  tt_memop_issue_arb #(.MAX_OUTST(MAX_OUTST)) dut (
    .i_clk             (clk),
    .i_reset_n         (i_reset_n),
    .i_ld_rts          (i_ld_rts),
    .i_ld_last_uop     (i_ld_last_uop),
    .o_ld_rtr          (o_ld_rtr),
    .i_st_rts          (i_st_rts),
    .i_st_last_uop     (i_st_last_uop),
    .o_st_rtr          (o_st_rtr),
    .o_ex_rts          (o_ex_rts),
    .o_ex_load         (o_ex_load),
    .o_ex_store        (o_ex_store),
    .o_ex_last_uop     (o_ex_last_uop),
    .i_ex_rtr          (i_ex_rtr),
    .i_completed_valid (i_completed_valid),
    .i_mem_req         (i_mem_req),
    .o_mem_req_rdy     (o_mem_req_rdy),
    .i_mem_resp        (i_mem_resp),
    .o_outst_cnt       (o_outst_cnt),
    .o_busy            (o_busy),
    .o_err             (o_err)
  );

  // scoreboard
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_ld(input logic last);
    exp_q.push_back({1'b1, 1'b0, last, 1'b1, 1'b0});
  endtask

  task automatic push_st(input logic last);
    exp_q.push_back({1'b0, 1'b1, last, 1'b0, 1'b1});
  endtask

  // monitor: every uop accepted at EX must match the oldest expected record
  always @(negedge clk) begin
    if (o_ex_rts && i_ex_rtr) begin
      logic [W-1:0] act;
      logic [W-1:0] exp;
      act = {o_ex_load, o_ex_store, o_ex_last_uop, o_ld_rtr, o_st_rtr};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL ex_uop_unexpected: got %0h expected none", act);
      end else begin
        exp = exp_q.pop_front();
        if (act !== exp) begin
          errors++;
          $display("FAIL ex_uop: got %0h expected %0h", act, exp);
        end
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_ld_rts = 0; i_ld_last_uop = 0; i_st_rts = 0; i_st_last_uop = 0;
    i_ex_rtr = 0; i_completed_valid = 0; i_mem_req = 0; i_mem_resp = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    i_reset_n = 0;
    repeat (2) step();
    i_reset_n = 1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    do_reset();
    settle();
    // reset state
    check("rst_cnt", 32'(o_outst_cnt), 0);
    check("rst_busy", 32'(o_busy), 0);
    check("rst_err", 32'(o_err), 0);
    check("rst_rdy", 32'(o_mem_req_rdy), 1);
    check("rst_ex_rts", 32'(o_ex_rts), 0);

    // ---- load-only, 3 uops ----
    i_ld_rts = 1; i_ld_last_uop = 0; i_ex_rtr = 1;
    settle();
    check("ld3_idle_rtr", 32'(o_ld_rtr), 0);
    check("ld3_idle_ex_rts", 32'(o_ex_rts), 0);
    step(); push_ld(0); settle();
    check("ld3_g1_rtr", 32'(o_ld_rtr), 1);
    check("ld3_g1_busy", 32'(o_busy), 1);
    check("ld3_g1_load", 32'(o_ex_load), 1);
    step(); push_ld(0); settle();
    check("ld3_g2_rtr", 32'(o_ld_rtr), 1);
    step(); i_ld_last_uop = 1; push_ld(1); settle();
    check("ld3_g3_rtr", 32'(o_ld_rtr), 1);
    step(); i_ld_rts = 0; i_ld_last_uop = 0; settle();
    check("ld3_wait_busy", 32'(o_busy), 1);
    check("ld3_wait_rtr", 32'(o_ld_rtr), 0);
    check("ld3_wait_ex_rts", 32'(o_ex_rts), 0);
    step(); i_completed_valid = 1; settle();
    check("ld3_wait_hold", 32'(o_busy), 1);
    step(); i_completed_valid = 0; settle();
    check("ld3_done_busy", 32'(o_busy), 0);
    check("ld3_done_err", 32'(o_err), 0);

    // ---- round robin, both streams, 1-uop instructions ----
    do_reset();
    i_ld_rts = 1; i_ld_last_uop = 1; i_st_rts = 1; i_st_last_uop = 1; i_ex_rtr = 1;
    step(); push_ld(1); settle();
    check("rr1_ld_rtr", 32'(o_ld_rtr), 1);
    check("rr1_st_rtr", 32'(o_st_rtr), 0);
    check("rr1_ex_store", 32'(o_ex_store), 0);
    step(); settle();
    check("rr1_wait_ld_rtr", 32'(o_ld_rtr), 0);
    check("rr1_wait_st_rtr", 32'(o_st_rtr), 0);
    i_completed_valid = 1;
    step(); i_completed_valid = 0; settle();
    check("rr1_idle_busy", 32'(o_busy), 0);
    check("rr1_idle_st_rtr", 32'(o_st_rtr), 0);
    step(); push_st(1); settle();
    check("rr2_st_rtr", 32'(o_st_rtr), 1);
    check("rr2_ld_rtr", 32'(o_ld_rtr), 0);
    check("rr2_ex_store", 32'(o_ex_store), 1);
    step(); i_completed_valid = 1;
    step(); i_completed_valid = 0;
    step(); push_ld(1); settle();
    check("rr3_ex_load", 32'(o_ex_load), 1);
    check("rr3_st_rtr", 32'(o_st_rtr), 0);
    step(); i_ld_rts = 0; i_st_rts = 0; i_completed_valid = 1;
    step(); i_completed_valid = 0; settle();
    check("rr_err", 32'(o_err), 0);

    // ---- backpressure on a 2-uop store ----
    i_st_rts = 1; i_st_last_uop = 0; i_ex_rtr = 1;
    step(); push_st(0); settle();
    check("bp_c1_rtr", 32'(o_st_rtr), 1);
    step(); i_st_last_uop = 1; i_ex_rtr = 0; settle();
    check("bp_c2_rtr", 32'(o_st_rtr), 0);
    check("bp_c2_ex_last", 32'(o_ex_last_uop), 1);
    step(); settle();
    check("bp_c3_still_granted", 32'(o_ex_rts), 1);
    i_ex_rtr = 1; push_st(1); settle();
    check("bp_c3_rtr", 32'(o_st_rtr), 1);
    step(); settle();
    check("bp_wait_ex_rts", 32'(o_ex_rts), 0);
    check("bp_wait_busy", 32'(o_busy), 1);
    i_st_rts = 0; i_st_last_uop = 0; i_completed_valid = 1;
    step(); i_completed_valid = 0; settle();
    check("bp_done_busy", 32'(o_busy), 0);

    // ---- credit counter ----
    i_mem_req = 1;
    for (int i = 0; i < 16; i++) step();
    settle();
    check("cr_full_cnt", 32'(o_outst_cnt), 16);
    check("cr_full_rdy", 32'(o_mem_req_rdy), 0);
    step(); settle();
    check("cr_full_hold", 32'(o_outst_cnt), 16);
    i_mem_req = 0; i_mem_resp = 1;
    for (int i = 0; i < 11; i++) step();
    settle();
    check("cr_cnt5", 32'(o_outst_cnt), 5);
    i_mem_req = 1;
    step(); settle();
    check("cr_req_resp", 32'(o_outst_cnt), 5);
    i_mem_req = 0;
    for (int i = 0; i < 5; i++) step();
    settle();
    check("cr_cnt0", 32'(o_outst_cnt), 0);
    check("cr_err_before", 32'(o_err), 0);
    step(); i_mem_resp = 0; settle();
    check("cr_underflow_err", 32'(o_err), 1);
    check("cr_underflow_cnt", 32'(o_outst_cnt), 0);

    // ---- completion with requests outstanding ----
    do_reset();
    i_ld_rts = 1; i_ld_last_uop = 1; i_ex_rtr = 1; i_mem_req = 1;
    step(); push_ld(1);
    step(); i_ld_rts = 0; i_ld_last_uop = 0; i_mem_req = 0; i_completed_valid = 1; settle();
    check("cmpl_cnt2", 32'(o_outst_cnt), 2);
    step(); i_completed_valid = 0; settle();
    check("cmpl_busy", 32'(o_busy), 0);
    check("cmpl_err", 32'(o_err), 1);

    // ---- stray completion in IDLE ----
    do_reset();
    settle();
    check("stray_err_clr", 32'(o_err), 0);
    i_completed_valid = 1;
    step(); i_completed_valid = 0; settle();
    check("stray_err", 32'(o_err), 1);
    check("stray_busy", 32'(o_busy), 0);
    repeat (2) step();
    settle();
    check("stray_sticky", 32'(o_err), 1);

    // ---- reset mid-grant after 1 of 3 uops ----
    do_reset();
    i_ld_rts = 1; i_ld_last_uop = 0; i_ex_rtr = 1; i_mem_req = 1;
    step(); push_ld(0);
    step(); i_mem_req = 0; i_reset_n = 0; settle();
    check("rmid_cnt_before", 32'(o_outst_cnt), 2);
    check("rmid_ld_rtr", 32'(o_ld_rtr), 0);
    check("rmid_ex_rts", 32'(o_ex_rts), 0);
    step();
    i_reset_n = 1; i_ld_rts = 1; i_ld_last_uop = 1; i_st_rts = 1; i_st_last_uop = 1;
    settle();
    check("rmid_cnt", 32'(o_outst_cnt), 0);
    check("rmid_busy", 32'(o_busy), 0);
    check("rmid_ld_rtr_idle", 32'(o_ld_rtr), 0);
    check("rmid_st_rtr_idle", 32'(o_st_rtr), 0);
    step(); push_ld(1); settle();
    check("rmid_load_wins", 32'(o_ex_load), 1);
    step(); i_ld_rts = 0; i_st_rts = 0; i_completed_valid = 1;
    step(); i_completed_valid = 0;
    repeat (2) step();
    settle();
    check("end_err", 32'(o_err), 0);
    check("end_queue_empty", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
